// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to instruction memory loader with checksum-gated CPU start
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_start_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LEN_LO = 3'd1, S_LEN_HI = 3'd2, S_DATA = 3'd3,
                         S_CHK = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6;
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;
  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   word_q, word_d, word_nx;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d, sum_nx;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d, done_q, done_d, start_q, start_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              busy, xfer, too_long, sum_ok;
  logic [15:0]       n;
  assign busy     = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
  assign xfer     = busy && byte_valid_i;
  assign n        = {byte_i, len_q[7:0]};
  assign too_long = {1'b0, n} > MAX_N;
  assign word_nx  = word_q + (ADDR_W+1)'(1);
  assign sum_nx   = sum_q + byte_i;
  assign sum_ok   = sum_nx == 8'd0;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    start_d = start_q;
    err_d   = err_q;
    if (!busy && load_i) begin
      state_d = S_LEN_LO;
      word_d  = '0;
      cnt_d   = '0;
      sum_d   = '0;
      start_d = 1'b0;
      err_d   = 1'b0;
    end else if (xfer && state_q == S_LEN_LO) begin
      len_d[7:0] = byte_i;
      state_d    = S_LEN_HI;
    end else if (xfer && state_q == S_LEN_HI) begin
      len_d[15:8] = byte_i;
      state_d     = too_long ? S_ERR : (n == 16'd0) ? S_CHK : S_DATA;
      err_d       = too_long;
    end else if (xfer && state_q == S_DATA) begin
      // bytes enter at the top so the first byte ends up least significant
      sum_d = sum_nx;
      cnt_d = cnt_q + 2'd1;
      asm_d = {byte_i, asm_q[23:8]};
      if (cnt_q == 2'd3) begin
        we_d    = 1'b1;
        addr_d  = word_q[ADDR_W-1:0];
        data_d  = {byte_i, asm_q};
        word_d  = word_nx;
        state_d = (word_nx == len_q[ADDR_W:0]) ? S_CHK : S_DATA;
      end
    end else if (xfer && state_q == S_CHK) begin
      state_d = sum_ok ? S_DONE : S_ERR;
      done_d  = sum_ok;
      start_d = sum_ok;
      err_d   = !sum_ok;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end
  assign byte_ready_o = busy;
  assign busy_o       = busy;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_data_o  = data_q;
  assign done_o       = done_q;
  assign cpu_start_o  = start_q;
  assign err_o        = err_q;
endmodule

// File: doc/imem_loader.md
# imem_loader

Streaming program loader for the pipelined CPU: accepts a framed byte stream, assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory from word 0. It verifies a trailing checksum and only then raises the CPU start signal. It sits between a byte source (UART receiver or host bridge) and the CPU's `Instruction_Memory` write port and `start_i`.

## Interface
- `ADDR_W`, 8: instruction memory word-address width (capacity 2^ADDR_W words).
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `load_i`  in  1  request a new load; sampled in IDLE, DONE, ERR only.
- `byte_i`  in  8  stream data byte.
- `byte_valid_i`  in  1  `byte_i` valid.
- `byte_ready_o`  out  1  loader can accept a byte; a byte transfers when valid & ready.
- `imem_we_o`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr_o`  out  ADDR_W  word address of the write.
- `imem_data_o`  out  32  word being written.
- `cpu_start_o`  out  1  level; high only after a successful load.
- `done_o`  out  1  one-cycle pulse on load success.
- `err_o`  out  1  level; high in ERR.
- `busy_o`  out  1  high in LEN_LO, LEN_HI, DATA, CHK.

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4·N data bytes (each word LSB first), one checksum byte CHK.
- Checksum rule: (sum of all data bytes + CHK) mod 256 == 0. Length bytes are excluded.
- States are IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
  - IDLE: on `load_i` go to LEN_LO.
  - LEN_LO: on transfer, latch low byte and go to LEN_HI.
  - LEN_HI: on transfer, latch high byte. If N > 2^ADDR_W, go to ERR. If N == 0, go to CHK. Otherwise go to DATA.
  - DATA: shift bytes into the word assembler with a 2-bit byte counter and accumulate an 8-bit sum. On the 4th byte, issue a write and increment the word index. After word N-1 is complete, go to CHK.
  - CHK: on transfer, go to DONE if the checksum rule holds, else ERR.
  - DONE: hold `cpu_start_o` high. `load_i` goes to LEN_LO.
  - ERR: hold `err_o` high. `load_i` goes to LEN_LO.
- Restart from DONE/ERR clears `cpu_start_o`, `err_o`, the sum, the byte counter and the word index.
- `load_i` in LEN_LO, LEN_HI, DATA or CHK is ignored.
- `byte_ready_o` is high exactly when `busy_o` is high. Bytes offered in IDLE, DONE or ERR are not consumed.
- Instruction memory beyond word N-1 is not touched.

## Timing
- Reset: state IDLE; every output is 0, including `imem_addr_o` and `imem_data_o`. Sum, counters and length are cleared.
- Reset mid-frame discards the frame; no further writes occur.
- `load_i` high at edge k makes `byte_ready_o` high from cycle k+1.
- Throughput is 1 byte per cycle. Bubbles (`byte_valid_i` low) stall without changing state.
- `imem_we_o`, `imem_addr_o` and `imem_data_o` are registered. The write is presented in the cycle after the edge that accepted the word's 4th byte, with `imem_we_o` high for that single cycle.
- Byte acceptance continues in parallel with a write; there is no ready drop.
- The CHK transfer at edge k produces `done_o` and `cpu_start_o` high in cycle k+1 on success, or `err_o` high in cycle k+1 on failure.
- The final word's write strobe and `done_o` never coincide: for N ≥ 1 the write leads `done_o` by at least one cycle.
- `done_o` lasts exactly one cycle.
- `cpu_start_o` drops in the cycle after a restarting `load_i` edge.

## Test plan
- Reset, then `load_i`; send 02 00, 93 00 50 00, 13 01 10 00, F9 → writes addr 0 = 0x00500093 and addr 1 = 0x00100113, one cycle each. `done_o` pulses once and `cpu_start_o` goes to 1 the cycle after F9 is accepted; `err_o` stays 0.
- Same frame with CHK 0xF8 → both writes occur, `err_o` = 1, `cpu_start_o` = 0, `byte_ready_o` = 0. A new `load_i` plus a correct frame then reaches DONE.
- N = 0: send 00 00, 00 → no `imem_we_o`, DONE with `cpu_start_o` = 1. With CHK 0x01 instead → ERR.
- ADDR_W = 8, send 01 01 (N = 257) → ERR after LEN_HI, no writes, ready low. N = 256 is accepted, with the last write at addr 255.
- Case 1 with `byte_valid_i` toggling every other cycle and `load_i` pulsed during DATA → identical writes and result; the `load_i` pulse has no effect.
- Reset asserted after 5 data bytes of case 1 → only the addr 0 write was issued, all outputs 0, state IDLE. Reloading the full frame succeeds.
